// File: rtl/rnm_sar_adc_pkg.sv
// Shared types and helpers for the real-number-model SAR ADC.
// Also provides the IS_NAN / IS_INF macros used by the optional checks
// (enabled with RNM_SAR_ADC_ASSERT_EN).
package rnm_sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_e;

    localparam logic [63:0] ExpMask  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] FracMask = 64'h000F_FFFF_FFFF_FFFF;

    // All-ones exponent with a non-zero fraction.
    function automatic logic real_is_nan(input real x);
        logic [63:0] b;
        b = $realtobits(x);
        return ((b & ExpMask) == ExpMask) && ((b & FracMask) != 64'd0);
    endfunction

    // All-ones exponent with a zero fraction, either sign.
    function automatic logic real_is_inf(input real x);
        logic [63:0] b;
        b = $realtobits(x);
        return ((b & ExpMask) == ExpMask) && ((b & FracMask) == 64'd0);
    endfunction

    // Threshold voltage of a code: vref * code / 2**n.
    function automatic real code_to_real(input int unsigned code, input int unsigned n,
                                         input real vref);
        return vref * real'(code) / real'(32'd1 << n);
    endfunction

endpackage

`ifndef IS_NAN
`define IS_NAN(x) rnm_sar_adc_pkg::real_is_nan(x)
`endif
`ifndef IS_INF
`define IS_INF(x) rnm_sar_adc_pkg::real_is_inf(x)
`endif

// File: rtl/rnm_sar_dac.sv
// Combinational reference DAC: maps a candidate code to its real threshold.
// Kept separate so the comparator path can be shared by a pipelined ADC.
module rnm_sar_dac
    import rnm_sar_adc_pkg::*;
#(
    parameter int unsigned N_BITS = 8,
    parameter real         VREF   = 1.0
) (
    input  logic [N_BITS-1:0] cand,
    output real               vth
);

    // Threshold for the candidate code.
    always_comb begin
        vth = code_to_real(32'(cand), N_BITS, VREF);
    end

endmodule

// File: rtl/rnm_sar_adc.sv
// Real-number-model successive-approximation ADC with start/ready/valid
// handshake. NaN/Inf inputs raise err, out-of-range inputs raise ovr and
// are clamped. Optional self-checks: define RNM_SAR_ADC_ASSERT_EN.
module rnm_sar_adc
    import rnm_sar_adc_pkg::*;
#(
    parameter int unsigned N_BITS = 8,
    parameter real         VREF   = 1.0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  real               vin,
    output logic              ready,
    output logic [N_BITS-1:0] code,
    output logic              valid,
    output logic              err,
    output logic              ovr
);

    state_e            state_q, state_d;
    real               vhold_q, vhold_d;
    logic [N_BITS-1:0] trial_q, trial_d;
    logic [3:0]        idx_q, idx_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;

    logic [N_BITS-1:0] cand;
    real               vth;

    assign cand = trial_q | (N_BITS'(1) << idx_q);

    rnm_sar_dac #(
        .N_BITS (N_BITS),
        .VREF   (VREF)
    ) u_dac (
        .cand (cand),
        .vth  (vth)
    );

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vhold_q <= 0.0;
            trial_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vhold_q <= vhold_d;
            trial_q <= trial_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: classify on accept, then resolve one bit per edge MSB first.
    // err/ovr are cleared together with the code write so all three stay
    // stable between valid pulses.
    always_comb begin
        state_d = state_q;
        vhold_d = vhold_q;
        trial_d = trial_q;
        idx_d   = idx_q;
        code_d  = code_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vhold_d = vin;
                    if (real_is_nan(vin) || real_is_inf(vin)) begin
                        code_d  = '0;
                        err_d   = 1'b1;
                        ovr_d   = 1'b0;
                        state_d = DONE;
                    end else if (vin < 0.0) begin
                        code_d  = '0;
                        err_d   = 1'b0;
                        ovr_d   = 1'b1;
                        state_d = DONE;
                    end else if (vin >= VREF) begin
                        code_d  = '1;
                        err_d   = 1'b0;
                        ovr_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        trial_d = '0;
                        idx_d   = 4'(N_BITS - 1);
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                // >= so a value exactly on a threshold keeps the bit.
                if (vhold_q >= vth) begin
                    trial_d = cand;
                end
                if (idx_q == 4'd0) begin
                    code_d  = (vhold_q >= vth) ? cand : trial_q;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and result outputs.
    always_comb begin
        ready = (state_q == IDLE);
        valid = (state_q == DONE);
        code  = code_q;
        err   = err_q;
        ovr   = ovr_q;
    end

`ifdef RNM_SAR_ADC_ASSERT_EN
    real    vhold_past_q;
    state_e state_past_q;

    // One-cycle history of the held sample and the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vhold_past_q <= 0.0;
            state_past_q <= IDLE;
        end else begin
            vhold_past_q <= vhold_q;
            state_past_q <= state_q;
        end
    end

    // Result consistency checks, evaluated on pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (valid && !err && !ovr) begin
                assert (code_to_real(32'(code_q), N_BITS, VREF) <= vhold_past_q &&
                        vhold_past_q < code_to_real(32'(code_q) + 32'd1, N_BITS, VREF));
            end
            if (valid) begin
                assert (err == (`IS_NAN(vhold_q) || `IS_INF(vhold_q)));
            end
            assert (!(valid && state_past_q == DONE));
            assert (state_q == IDLE || !ready);
        end
    end
`endif

endmodule
